result_recorder: RTL and testbench
==================================

RESULT_RECORDER -- requirements
Module: result_recorder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the bit width of one captured sample.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of sample entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  the reset; asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  a request to begin a new capture session.
REQ-006 The block SHALL have port stop  input  1  a request to end the capture early.
REQ-007 The block SHALL have port sample_valid  input  1  marks sample_data as valid this cycle.
REQ-008 The block SHALL have port sample_data  input  WIDTH  the DUT result to record.
REQ-009 The block SHALL have port rd_req  input  1  a request for the next recorded sample.
REQ-010 The block SHALL have port rd_data  output  WIDTH  the returned sample.
REQ-011 The block SHALL have port rd_valid  output  1  marks rd_data as valid this cycle.
REQ-012 The block SHALL have port count  output  $clog2(DEPTH)+1  the number of samples stored in the current session.
REQ-013 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 The block SHALL have port full  output  1  high when count equals DEPTH.
REQ-015 The block SHALL have port overflow  output  1  sticky; high once a sample is dropped.
REQ-016 The block SHALL have port done  output  1  a one-cycle pulse when draining completes.

Function
REQ-017 The block SHALL implement the states IDLE, CAPTURE and DRAIN.
REQ-018 In IDLE, start SHALL clear count, the write pointer, the read pointer and overflow, and the next state SHALL be CAPTURE.
REQ-019 In CAPTURE, when sample_valid=1 and full=0, the block SHALL write sample_data at the write pointer and increment both the write pointer and count in the same cycle.
REQ-020 In CAPTURE, when sample_valid=1 and full=1, the block SHALL drop the sample, set overflow, and leave count unchanged.
REQ-021 CAPTURE SHALL go to DRAIN on the cycle after stop=1, or on the cycle after count reaches DEPTH.
REQ-022 When stop=1 and sample_valid=1 occur together, the block SHALL store the sample first and then transition.
REQ-023 In DRAIN, when rd_req=1 and the read pointer is less than count, rd_data SHALL present the entry at the read pointer with rd_valid=1 exactly one cycle later, and the read pointer SHALL increment.
REQ-024 In DRAIN, a rd_req made when the read pointer equals count SHALL be ignored, with no rd_valid.
REQ-025 In DRAIN, when the last stored entry is returned, the block SHALL pulse done on the same cycle as that rd_valid and enter IDLE.
REQ-026 If DRAIN is entered with count=0, the block SHALL pulse done on the next cycle and return to IDLE.
REQ-027 The block SHALL ignore start outside IDLE, rd_req outside DRAIN, and sample_valid outside CAPTURE.
REQ-028 In IDLE, count and overflow SHALL hold their last session values until the next start.
REQ-029 rd_data SHALL hold its last value when rd_valid=0.

Reset
REQ-030 Reset SHALL force state to IDLE, count=0, both pointers=0, overflow=0, full=0, busy=0, done=0, rd_valid=0 and rd_data=0, asynchronously and at any point in a session.
REQ-031 The storage contents SHALL NOT be required to reset.
REQ-032 The first start SHALL be accepted on the first rising edge after reset is released.

Structure
REQ-033 A shared package recorder_pkg SHALL hold the state enum recorder_state_t (IDLE, CAPTURE, DRAIN) and the default WIDTH and DEPTH constants.
REQ-034 Storage SHALL be one sub-module, recorder_mem: a single-clock memory of DEPTH x WIDTH with one synchronous write port and one synchronous read port of one-cycle latency, with no reset.
REQ-035 The block SHALL contain no combinational path from any input to rd_data or rd_valid.

Verification
REQ-036 Scenario: reset; start; 5 samples 0x1..0x5 on consecutive cycles; stop; 5 rd_req -> rd_data 0x1..0x5 in order, count=5, done coincident with the 5th rd_valid, overflow=0.
REQ-037 Scenario: DEPTH=16; start; 18 consecutive samples -> full=1 after the 16th sample, overflow=1, count=16, drain returns only the first 16 samples.
REQ-038 Scenario: start; stop in the same cycle as sample_valid with 0xAA -> count=1, first read returns 0xAA.
REQ-039 Scenario: start; immediate stop with no samples -> done pulses one cycle after DRAIN is entered, state returns to IDLE, count=0.
REQ-040 Scenario: assert reset mid-DRAIN after 2 of 4 reads -> all outputs at reset values within the same cycle, and a new session behaves as in REQ-036.
REQ-041 Scenario: rd_req while in CAPTURE, and start while in DRAIN -> no rd_valid, no state change, stored data unchanged.

Source files
------------

// File: rtl/recorder_pkg.sv
// recorder_pkg
//    Shared definitions for the result recorder: the session state encoding,
//    the default sample width and entry count, and a small pointer helper.
package recorder_pkg;

   localparam int REC_WIDTH = 32;
   localparam int REC_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } recorder_state_t;

   // Width of a counter that must be able to hold the value DEPTH itself.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/recorder_mem.sv
// recorder_mem
//    Single-clock DEPTH x WIDTH sample store. One synchronous write port and
//    one synchronous read port; read data appears one cycle after i_re and
//    holds until the next read. Contents are not reset.
//
//    Ports
//       i_clk    clock
//       i_we     write enable
//       i_waddr  write address
//       i_wdata  write data
//       i_re     read enable
//       i_raddr  read address
//       o_rdata  registered read data
module recorder_mem
   import recorder_pkg::*;
#(
   parameter int WIDTH = REC_WIDTH,
   parameter int DEPTH = REC_DEPTH
) (
   input  logic                       i_clk,
   input  logic                       i_we,
   input  logic [$clog2(DEPTH)-1:0]   i_waddr,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_re,
   input  logic [$clog2(DEPTH)-1:0]   i_raddr,
   output logic [WIDTH-1:0]           o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Write port.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port with one-cycle latency; output holds between reads.
   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/result_recorder.sv
// result_recorder
//    Captures a session of DUT result samples into a small memory and then
//    hands them back one per request. Sessions run IDLE -> CAPTURE -> DRAIN
//    -> IDLE. Samples beyond DEPTH are dropped and flagged by a sticky
//    overflow bit. All outputs are driven from registers.
//
//    Ports
//       clk           clock, rising edge
//       reset         asynchronous, active-high reset
//       start         begin a new session (IDLE only)
//       stop          end capture early (CAPTURE only)
//       sample_valid  sample_data valid this cycle (CAPTURE only)
//       sample_data   sample to record
//       rd_req        request next stored sample (DRAIN only)
//       rd_data       returned sample, holds when rd_valid=0
//       rd_valid      rd_data valid, one cycle after an accepted rd_req
//       count         samples stored in the current/last session
//       busy          state is not IDLE
//       full          count equals DEPTH
//       overflow      sticky, a sample was dropped this session
//       done          one-cycle pulse when draining completes
module result_recorder
   import recorder_pkg::*;
#(
   parameter int WIDTH = REC_WIDTH,
   parameter int DEPTH = REC_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     sample_valid,
   input  logic [WIDTH-1:0]         sample_data,
   input  logic                     rd_req,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     full,
   output logic                     overflow,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   recorder_state_t r_state;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_rd_ptr;
   logic            r_overflow;
   logic            r_full;
   logic            r_busy;
   logic            r_done;
   logic            r_rd_valid;
   logic            r_rd_seen;

   recorder_state_t w_state_nxt;
   logic [CW-1:0]   w_count_nxt;
   logic [AW-1:0]   w_wr_ptr_nxt;
   logic [CW-1:0]   w_rd_ptr_nxt;
   logic            w_overflow_nxt;
   logic            w_done_nxt;
   logic            w_rd_valid_nxt;
   logic            w_mem_we;
   logic            w_mem_re;
   logic [WIDTH-1:0] w_mem_q;

   // Session state machine: next-state and datapath control.
   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_wr_ptr_nxt   = r_wr_ptr;
      w_rd_ptr_nxt   = r_rd_ptr;
      w_overflow_nxt = r_overflow;
      w_done_nxt     = 1'b0;
      w_rd_valid_nxt = 1'b0;
      w_mem_we       = 1'b0;
      w_mem_re       = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_count_nxt    = {CW{1'b0}};
               w_wr_ptr_nxt   = {AW{1'b0}};
               w_rd_ptr_nxt   = {CW{1'b0}};
               w_overflow_nxt = 1'b0;
               w_state_nxt    = CAPTURE;
            end else begin
               w_state_nxt    = IDLE;
            end
         end

         CAPTURE: begin
            if (sample_valid && !r_full) begin
               w_mem_we     = 1'b1;
               w_wr_ptr_nxt = r_wr_ptr + AW'(1);
               w_count_nxt  = r_count + CW'(1);
            end else if (sample_valid) begin
               w_overflow_nxt = 1'b1;
            end else begin
               w_count_nxt  = r_count;
            end
            // full is registered, so the state stays in CAPTURE for one cycle
            // with full=1; a sample offered then is the one that overflows.
            if (stop || r_full) begin
               w_state_nxt = DRAIN;
            end else begin
               w_state_nxt = CAPTURE;
            end
         end

         DRAIN: begin
            if (r_count == {CW{1'b0}}) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end else if (rd_req && (r_rd_ptr < r_count)) begin
               w_mem_re       = 1'b1;
               w_rd_valid_nxt = 1'b1;
               w_rd_ptr_nxt   = r_rd_ptr + CW'(1);
               if ((r_rd_ptr + CW'(1)) == r_count) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DRAIN;
               end
            end else begin
               w_state_nxt = DRAIN;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, pointers, counters and output flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_count    <= {CW{1'b0}};
         r_wr_ptr   <= {AW{1'b0}};
         r_rd_ptr   <= {CW{1'b0}};
         r_overflow <= 1'b0;
         r_full     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_seen  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_overflow <= w_overflow_nxt;
         r_full     <= (w_count_nxt == CW'(DEPTH));
         r_busy     <= (w_state_nxt != IDLE);
         r_done     <= w_done_nxt;
         r_rd_valid <= w_rd_valid_nxt;
         r_rd_seen  <= r_rd_seen | w_mem_re;
      end
   end

   recorder_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .i_clk   (clk),
      .i_we    (w_mem_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (sample_data),
      .i_re    (w_mem_re),
      .i_raddr (r_rd_ptr[AW-1:0]),
      .o_rdata (w_mem_q)
   );

   // The memory has no reset, so rd_data is forced to zero until the first
   // read after reset; afterwards the memory's read register holds the value.
   assign rd_data  = r_rd_seen ? w_mem_q : {WIDTH{1'b0}};
   assign rd_valid = r_rd_valid;
   assign count    = r_count;
   assign busy     = r_busy;
   assign full     = r_full;
   assign overflow = r_overflow;
   assign done     = r_done;

endmodule

// File: tb/tb_result_recorder.sv
module tb_result_recorder;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             sample_valid = 1'b0;
   logic [WIDTH-1:0] sample_data = '0;
   logic             rd_req = 1'b0;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [4:0]       count;
   logic             busy;
   logic             full;
   logic             overflow;
   logic             done;

   int total = 0;
   int bad   = 0;

   result_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .rd_req       (rd_req),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .busy         (busy),
      .full         (full),
      .overflow     (overflow),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_reset(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_rdv"}, 32'(rd_valid), 32'd0);
      chk({tag, "_rdd"}, rd_data, 32'd0);
      chk({tag, "_cnt"}, 32'(count), 32'd0);
   endtask

   // start; samples 1..5; stop; 5 reads.
   task automatic basic_session(input string tag);
      start = 1'b1; step(); start = 1'b0;
      chk({tag, "_busy_cap"}, 32'(busy), 32'd1);
      for (int i = 1; i <= 5; i++) begin
         sample_valid = 1'b1; sample_data = 32'(i); step();
      end
      sample_valid = 1'b0;
      chk({tag, "_cnt5"}, 32'(count), 32'd5);
      stop = 1'b1; step(); stop = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         rd_req = 1'b1; step();
         chk($sformatf("%s_rdv%0d", tag, i), 32'(rd_valid), 32'd1);
         chk($sformatf("%s_rdd%0d", tag, i), rd_data, 32'(i));
         chk($sformatf("%s_done%0d", tag, i), 32'(done), (i == 5) ? 32'd1 : 32'd0);
      end
      rd_req = 1'b0; step();
      chk({tag, "_rdv_after"}, 32'(rd_valid), 32'd0);
      chk({tag, "_rdd_hold"}, rd_data, 32'd5);
      chk({tag, "_done_after"}, 32'(done), 32'd0);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_cnt_end"}, 32'(count), 32'd5);
      chk({tag, "_ovf_end"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      // Reset state.
      step(); step();
      check_idle_reset("rst");
      reset = 1'b0;

      // Basic five-sample session.
      basic_session("s1");

      // Overflow: 18 consecutive samples into a 16-entry store.
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 18; i++) begin
         sample_valid = 1'b1; sample_data = 32'h100 + 32'(i); step();
         if (i == 15) begin
            chk("ovf_full16", 32'(full), 32'd1);
            chk("ovf_cnt16", 32'(count), 32'd16);
            chk("ovf_flag16", 32'(overflow), 32'd0);
         end
      end
      sample_valid = 1'b0;
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_cnt", 32'(count), 32'd16);
      chk("ovf_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 16; i++) begin
         rd_req = 1'b1; step();
         chk($sformatf("ovf_rdd%0d", i), rd_data, 32'h100 + 32'(i));
         chk($sformatf("ovf_done%0d", i), 32'(done), (i == 15) ? 32'd1 : 32'd0);
      end
      rd_req = 1'b1; step(); rd_req = 1'b0;
      chk("ovf_extra_rdv", 32'(rd_valid), 32'd0);
      chk("ovf_idle", 32'(busy), 32'd0);

      // stop together with a sample.
      start = 1'b1; step(); start = 1'b0;
      sample_valid = 1'b1; sample_data = 32'hAA; stop = 1'b1; step();
      sample_valid = 1'b0; stop = 1'b0;
      chk("ss_cnt", 32'(count), 32'd1);
      chk("ss_ovf_cleared", 32'(overflow), 32'd0);
      rd_req = 1'b1; step(); rd_req = 1'b0;
      chk("ss_rdv", 32'(rd_valid), 32'd1);
      chk("ss_rdd", rd_data, 32'hAA);
      chk("ss_done", 32'(done), 32'd1);

      // Empty session.
      start = 1'b1; step(); start = 1'b0;
      stop = 1'b1; step(); stop = 1'b0;
      chk("em_busy_drain", 32'(busy), 32'd1);
      chk("em_done_early", 32'(done), 32'd0);
      chk("em_cnt", 32'(count), 32'd0);
      step();
      chk("em_done", 32'(done), 32'd1);
      chk("em_idle", 32'(busy), 32'd0);
      step();
      chk("em_done_pulse", 32'(done), 32'd0);

      // Reset in the middle of a drain.
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sample_valid = 1'b1; sample_data = 32'h11 + 32'(i); step();
      end
      sample_valid = 1'b0;
      stop = 1'b1; step(); stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_req = 1'b1; step();
         chk($sformatf("mr_rdd%0d", i), rd_data, 32'h11 + 32'(i));
      end
      rd_req = 1'b0;
      reset = 1'b1; #1;
      check_idle_reset("mr");
      #2; reset = 1'b0;
      basic_session("s2");

      // Ignored requests: rd_req in CAPTURE, start/sample_valid in DRAIN.
      start = 1'b1; step(); start = 1'b0;
      sample_valid = 1'b1; sample_data = 32'h21; step();
      sample_data = 32'h22; step();
      sample_valid = 1'b0;
      rd_req = 1'b1; step(); rd_req = 1'b0;
      chk("ig_rdv_cap", 32'(rd_valid), 32'd0);
      chk("ig_cnt_cap", 32'(count), 32'd2);
      chk("ig_busy_cap", 32'(busy), 32'd1);
      stop = 1'b1; step(); stop = 1'b0;
      start = 1'b1; sample_valid = 1'b1; sample_data = 32'h99; step();
      start = 1'b0; sample_valid = 1'b0;
      chk("ig_busy_drain", 32'(busy), 32'd1);
      chk("ig_cnt_drain", 32'(count), 32'd2);
      chk("ig_rdv_drain", 32'(rd_valid), 32'd0);
      rd_req = 1'b1; step();
      chk("ig_rdd0", rd_data, 32'h21);
      chk("ig_done0", 32'(done), 32'd0);
      step(); rd_req = 1'b0;
      chk("ig_rdd1", rd_data, 32'h22);
      chk("ig_done1", 32'(done), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
